flap_glyph_sequencer: RTL and testbench



---
 rtl/flap_glyph_sequencer_pkg.sv | 32 +++
 rtl/flap_glyph_sequencer_if.sv | 9 +
 rtl/flap_glyph_sequencer_glyph_rom.sv | 61 ++++++
 rtl/flap_glyph_sequencer.sv | 140 ++++++++++++++
 tb/tb_flap_glyph_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/flap_glyph_sequencer_pkg.sv
// Shared types and constants for the split-flap glyph sequencer.
// Glyph codes: 0 blank, 1-26 A-Z, 27-36 0-9, 37 '-', 38 '.', 39 '!'.
package split_flap_pkg;

    typedef enum logic [1:0] {IDLE, FLIP, SETTLE} state_e;

    localparam int DEF_NUM_GLYPHS   = 40;
    localparam int DEF_SETTLE_TICKS = 2;

    localparam logic [5:0] GLYPH_BLANK = 6'd0;
    localparam logic [5:0] GLYPH_A     = 6'd1;
    localparam logic [5:0] GLYPH_Z     = 6'd26;
    localparam logic [5:0] GLYPH_0     = 6'd27;
    localparam logic [5:0] GLYPH_9     = 6'd36;
    localparam logic [5:0] GLYPH_DASH  = 6'd37;
    localparam logic [5:0] GLYPH_DOT   = 6'd38;
    localparam logic [5:0] GLYPH_BANG  = 6'd39;

    localparam logic [63:0] BLANK_PATTERN = 64'hFFFF_FFFF_FFFF_FFFF;

    // 5-column font {c0,c1,c2,c3,c4} (active-high, bit 0 = top row) placed
    // into columns 1..5 of the 8x8 panel and inverted to active-low.
    function automatic logic [63:0] place_font(input logic [39:0] f);
        logic [63:0] lit;
        lit = '0;
        for (int i = 0; i < 5; i++) begin
            lit[8*(i+1) +: 8] = f[8*(4-i) +: 8];
        end
        return ~lit;
    endfunction

endpackage

// File: rtl/flap_glyph_sequencer_if.sv
// Target-character valid/ready handshake into the glyph sequencer.
interface flap_glyph_sequencer_if;
    logic [5:0] target_char;
    logic       target_valid;
    logic       target_ready;

    modport master (output target_char, output target_valid, input  target_ready);
    modport slave  (input  target_char, input  target_valid, output target_ready);
endinterface

// File: rtl/flap_glyph_sequencer_glyph_rom.sv
// Combinational glyph code -> 64-bit active-low column pattern lookup.
module glyph_rom
    import split_flap_pkg::*;
(
    input  logic [5:0]  code,
    output logic [63:0] rows_off
);

    logic [39:0] font;
    logic        known;

    always_comb begin
        font  = '0;
        known = 1'b1;
        case (code)
            6'd0:  font = 40'h00_00_00_00_00;
            6'd1:  font = 40'h7C_12_11_12_7C;
            6'd2:  font = 40'h7F_49_49_49_36;
            6'd3:  font = 40'h3E_41_41_41_22;
            6'd4:  font = 40'h7F_41_41_22_1C;
            6'd5:  font = 40'h7F_49_49_49_41;
            6'd6:  font = 40'h7F_09_09_09_01;
            6'd7:  font = 40'h3E_41_49_49_7A;
            6'd8:  font = 40'h7F_08_08_08_7F;
            6'd9:  font = 40'h00_41_7F_41_00;
            6'd10: font = 40'h20_40_41_3F_01;
            6'd11: font = 40'h7F_08_14_22_41;
            6'd12: font = 40'h7F_40_40_40_40;
            6'd13: font = 40'h7F_02_0C_02_7F;
            6'd14: font = 40'h7F_04_08_10_7F;
            6'd15: font = 40'h3E_41_41_41_3E;
            6'd16: font = 40'h7F_09_09_09_06;
            6'd17: font = 40'h3E_41_51_21_5E;
            6'd18: font = 40'h7F_09_19_29_46;
            6'd19: font = 40'h46_49_49_49_31;
            6'd20: font = 40'h01_01_7F_01_01;
            6'd21: font = 40'h3F_40_40_40_3F;
            6'd22: font = 40'h1F_20_40_20_1F;
            6'd23: font = 40'h3F_40_38_40_3F;
            6'd24: font = 40'h63_14_08_14_63;
            6'd25: font = 40'h07_08_70_08_07;
            6'd26: font = 40'h61_51_49_45_43;
            6'd27: font = 40'h3E_51_49_45_3E;
            6'd28: font = 40'h00_42_7F_40_00;
            6'd29: font = 40'h42_61_51_49_46;
            6'd30: font = 40'h21_41_45_4B_31;
            6'd31: font = 40'h18_14_12_7F_10;
            6'd32: font = 40'h27_45_45_45_39;
            6'd33: font = 40'h3C_4A_49_49_30;
            6'd34: font = 40'h01_71_09_05_03;
            6'd35: font = 40'h36_49_49_49_36;
            6'd36: font = 40'h06_49_49_29_1E;
            6'd37: font = 40'h08_08_08_08_08;
            6'd38: font = 40'h00_60_60_00_00;
            6'd39: font = 40'h00_00_5F_00_00;
            default: known = 1'b0;
        endcase
        rows_off = known ? place_font(font) : BLANK_PATTERN;
    end

endmodule

// File: rtl/flap_glyph_sequencer.sv
// Split-flap style glyph stepper feeding the 8x8 column-scan driver.
// Optional FLAP_BLANK_STEP_EN: each advance spends one extra tick on a blank frame.
module flap_glyph_sequencer
    import split_flap_pkg::*;
#(
    parameter int NUM_GLYPHS   = DEF_NUM_GLYPHS,
    parameter int SETTLE_TICKS = DEF_SETTLE_TICKS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step_tick,
    flap_glyph_sequencer_if.slave  tgt_if,
    output logic [63:0]            col_rows_off,
    output logic [7:0]             cols_on,
    output logic [5:0]             cur_char,
    output logic                   busy,
    output logic                   done
);

    localparam logic [5:0] LAST_CODE   = 6'(NUM_GLYPHS - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_TICKS);

    state_e      state_q, state_d;
    logic [5:0]  cur_q, cur_d;
    logic [5:0]  tgt_q, tgt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic [63:0] rows_q, rows_d;
    logic [63:0] rom_rows;
    logic [5:0]  next_code;
    logic [5:0]  accepted;
    logic        adv;
    logic        blank_frame;
`ifdef FLAP_BLANK_STEP_EN
    logic        phase_q, phase_d;
`endif

    glyph_rom u_rom (
        .code     (cur_q),
        .rows_off (rom_rows)
    );

    assign next_code = (cur_q == LAST_CODE) ? GLYPH_BLANK : cur_q + 6'd1;
    // Out-of-range requests fall back to the blank glyph.
    assign accepted  = (tgt_if.target_char > LAST_CODE) ? GLYPH_BLANK : tgt_if.target_char;

`ifdef FLAP_BLANK_STEP_EN
    assign adv         = step_tick && phase_q;
    assign blank_frame = phase_q;
`else
    assign adv         = step_tick;
    assign blank_frame = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef FLAP_BLANK_STEP_EN
        phase_d = phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (tgt_if.target_valid && ready_q) begin
                    tgt_d = accepted;
                    if (accepted != cur_q) begin
                        state_d = FLIP;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
            end
            FLIP: begin
`ifdef FLAP_BLANK_STEP_EN
                if (step_tick) phase_d = ~phase_q;
`endif
                if (adv) begin
                    cur_d = next_code;
                    if (next_code == tgt_q) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (step_tick) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        rows_d  = blank_frame ? BLANK_PATTERN : rom_rows;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= GLYPH_BLANK;
            tgt_q   <= GLYPH_BLANK;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rows_q  <= BLANK_PATTERN;
`ifdef FLAP_BLANK_STEP_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            rows_q  <= rows_d;
`ifdef FLAP_BLANK_STEP_EN
            phase_q <= phase_d;
`endif
        end
    end

    assign tgt_if.target_ready = ready_q;
    assign col_rows_off        = rows_q;
    assign cols_on             = 8'hFF;
    assign cur_char            = cur_q;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_flap_glyph_sequencer.sv
// Self-checking bench: target vector table plus hand-written corner sequences.
module tb_flap_glyph_sequencer;

    localparam int          NG     = 40;
    localparam int          SETTLE = 2;
    localparam logic [63:0] BLANK  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step_tick = 1'b0;
    logic [63:0] col_rows_off;
    logic [7:0]  cols_on;
    logic [5:0]  cur_char;
    logic        busy, done;

    flap_glyph_sequencer_if tif ();

    flap_glyph_sequencer #(.NUM_GLYPHS(NG), .SETTLE_TICKS(SETTLE)) dut (
        .clk          (clk),
        .reset        (reset),
        .step_tick    (step_tick),
        .tgt_if       (tif),
        .col_rows_off (col_rows_off),
        .cols_on      (cols_on),
        .cur_char     (cur_char),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  tgt;
        logic [5:0]  fin;
        logic [63:0] rows;
    } vec_t;

    vec_t       vecs [7];
    logic [5:0] exp_q [$];
    logic [5:0] model_cur;
    int         checks = 0;
    int         errors = 0;
    int         done_seen = 0;
    logic       ready_at_done = 1'b0;

    always @(negedge clk) begin
        if (done) begin
            done_seen++;
            ready_at_done = tif.target_ready;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        step_tick = 1'b1;
        @(posedge clk);
        #1 step_tick = 1'b0;
    endtask

    task automatic send_target(input logic [5:0] t);
        @(negedge clk);
        check("target_ready_idle", 64'(tif.target_ready), 64'd1);
        tif.target_valid = 1'b1;
        tif.target_char  = t;
        @(posedge clk);
        #1 tif.target_valid = 1'b0;
        @(negedge clk);
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    // Model forward rotation, queue expected codes, then tick and compare.
    task automatic flip_to(input logic [5:0] tgt, input int inject_at);
        logic [5:0] c;
        logic [5:0] e;
        int n;
        int d0;
        c  = model_cur;
        d0 = done_seen;
        n  = 0;
        while (c != tgt && n < 64) begin
            c = (c == 6'(NG - 1)) ? 6'd0 : c + 6'd1;
            exp_q.push_back(c);
            n++;
        end
        n = 0;
        while (exp_q.size() > 0) begin
            if (n == inject_at) begin
                @(negedge clk);
                check("ready_low_in_flip", 64'(tif.target_ready), 64'd0);
                tif.target_valid = 1'b1;
                tif.target_char  = 6'd9;
                @(posedge clk);
                #1 tif.target_valid = 1'b0;
            end
`ifdef FLAP_BLANK_STEP_EN
            pulse_tick();
            @(negedge clk);
            check("cur_hold_blank_tick", 64'(cur_char), 64'(model_cur));
            @(negedge clk);
            check("rows_blank_frame", col_rows_off, BLANK);
`endif
            pulse_tick();
            @(negedge clk);
            e = exp_q.pop_front();
            check("cur_char_step", 64'(cur_char), 64'(e));
            model_cur = e;
            n++;
        end
        check("no_done_in_flip", 64'(done_seen), 64'(d0));
    endtask

    task automatic settle_and_done(input logic [63:0] exp_rows);
        int d0;
        d0 = done_seen;
        @(negedge clk);
        check("rows_glyph", col_rows_off, exp_rows);
        check("busy_in_settle", 64'(busy), 64'd1);
        repeat (SETTLE) pulse_tick();
        check("no_early_done", 64'(done_seen), 64'(d0));
        for (int i = 0; i < 8 && done_seen == d0; i++) @(negedge clk);
        check("done_pulse", 64'(done_seen), 64'(d0 + 1));
        check("ready_with_done", 64'(ready_at_done), 64'd1);
        repeat (3) @(negedge clk);
        check("done_single", 64'(done_seen), 64'(d0 + 1));
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{tgt: 6'd3,  fin: 6'd3,  rows: ~64'h0000_2241_4141_3E00};
        vecs[1] = '{tgt: 6'd38, fin: 6'd38, rows: ~64'h0000_0000_6060_0000};
        vecs[2] = '{tgt: 6'd1,  fin: 6'd1,  rows: ~64'h0000_7C12_1112_7C00};
        vecs[3] = '{tgt: 6'd5,  fin: 6'd5,  rows: ~64'h0000_4149_4949_7F00};
        vecs[4] = '{tgt: 6'd5,  fin: 6'd5,  rows: ~64'h0000_4149_4949_7F00};
        vecs[5] = '{tgt: 6'd50, fin: 6'd0,  rows: BLANK};
        vecs[6] = '{tgt: 6'd39, fin: 6'd39, rows: ~64'h0000_0000_5F00_0000};

        tif.target_valid = 1'b0;
        tif.target_char  = 6'd0;
        model_cur        = 6'd0;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            check("ready_in_reset", 64'(tif.target_ready), 64'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_cur_char", 64'(cur_char), 64'd0);
        check("rst_rows", col_rows_off, BLANK);
        check("rst_cols_on", 64'(cols_on), 64'hFF);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(tif.target_ready), 64'd1);

        for (int v = 0; v < 7; v++) begin
            send_target(vecs[v].tgt);
            flip_to(vecs[v].fin, -1);
            settle_and_done(vecs[v].rows);
            check("final_cur", 64'(cur_char), 64'(vecs[v].fin));
        end

        // Wrap 39 -> 0 -> 1 -> 2 with a stray request mid-flip.
        send_target(6'd2);
        flip_to(6'd2, 1);
        settle_and_done(~64'h0000_3649_4949_7F00);
        check("stray_target_ignored", 64'(cur_char), 64'd2);

        // Reset in the middle of a flip aborts without done.
        send_target(6'd10);
        for (int k = 1; k <= 3; k++) begin
`ifdef FLAP_BLANK_STEP_EN
            pulse_tick();
`endif
            pulse_tick();
            @(negedge clk);
            check("pre_reset_step", 64'(cur_char), 64'(2 + k));
        end
        begin
            int d0;
            d0 = done_seen;
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check("midrst_cur", 64'(cur_char), 64'd0);
            check("midrst_busy", 64'(busy), 64'd0);
            check("midrst_rows", col_rows_off, BLANK);
            repeat (4) pulse_tick();
            @(negedge clk);
            check("midrst_no_done", 64'(done_seen), 64'(d0));
            check("midrst_cur_hold", 64'(cur_char), 64'd0);
            check("midrst_ready", 64'(tif.target_ready), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
